// File: rtl/mtm_alu_result_rx.sv
// mtm_alu_result_rx
// Deserialises the ALU result stream and reassembles result and error frames.
//
// Packet: 11 bits, MSB first: start(0), type(0=data,1=ctl), payload[7:0], stop(1).
// Result frame: 4 data packets (C[31:24] first) + ctl {0, flags[3:0], crc[2:0]}.
// Error frame : 1 ctl packet {1, err_flags[5:0], parity}.
//
// Parameters
//   CHECK_CRC    : 1 = check CRC-3 of result frames, 0 = crc_ok forced to 1
//   CHECK_PARITY : 1 = check parity of error frames, 0 = crc_ok forced to 1
// Ports
//   clk       in   posedge clock
//   rst       in   synchronous active-high reset
//   sin       in   serial stream, idle high
//   C         out  received result word
//   flags     out  received {carry, overflow, zero, negative}
//   crc       out  received CRC field
//   err_flags out  received error-packet flags
//   is_err    out  last accepted frame was an error packet
//   crc_ok    out  CRC / parity of the last accepted frame matched
//   valid     out  one-cycle pulse, frame accepted
//   frame_err out  one-cycle pulse, malformed frame discarded
module mtm_alu_result_rx #(
   parameter int CHECK_CRC    = 1,
   parameter int CHECK_PARITY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic [31:0] C,
   output logic [3:0]  flags,
   output logic [2:0]  crc,
   output logic [5:0]  err_flags,
   output logic        is_err,
   output logic        crc_ok,
   output logic        valid,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TYPE = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [2:0]  bit_cnt_r;
   logic        type_r;
   logic [7:0]  payload_r;
   logic [2:0]  pkt_cnt_r, pkt_cnt_nxt_s;
   logic [31:0] data_r;
   logic        acc_res_s, acc_err_s, ferr_s, shift_data_s;

   // CRC-3, x^3+x+1, init 000, MSB first
   function automatic logic [2:0] crc3_f(input logic [36:0] d);
      logic [2:0] c;
      logic       fb;
      c = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb = d[i] ^ c[2];
         c  = {c[1], c[0] ^ fb, fb};
      end
      return c;
   endfunction

   // error-packet parity: bit0 equals XOR of bits 7..1
   function automatic logic parity_ok_f(input logic [7:0] p);
      return ((^p[7:1]) == p[0]);
   endfunction

   // bit-level next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (sin == 1'b0) state_nxt_s = TYPE;
            else             state_nxt_s = IDLE;
         end
         TYPE: state_nxt_s = DATA;
         DATA: begin
            if (bit_cnt_r == 3'd7) state_nxt_s = STOP;
            else                   state_nxt_s = DATA;
         end
         STOP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // packet disposition, evaluated while the stop bit is on sin
   always_comb begin
      acc_res_s     = 1'b0;
      acc_err_s     = 1'b0;
      ferr_s        = 1'b0;
      shift_data_s  = 1'b0;
      pkt_cnt_nxt_s = pkt_cnt_r;
      if (state_r == STOP) begin
         if (sin == 1'b0) begin
            ferr_s        = 1'b1;
            pkt_cnt_nxt_s = 3'd0;
         end else if (type_r == 1'b0) begin
            if (pkt_cnt_r == 3'd4) begin
               ferr_s        = 1'b1;
               pkt_cnt_nxt_s = 3'd0;
            end else begin
               shift_data_s  = 1'b1;
               pkt_cnt_nxt_s = pkt_cnt_r + 3'd1;
            end
         end else begin
            // any ctl packet ends the frame, good or bad
            pkt_cnt_nxt_s = 3'd0;
            if ((pkt_cnt_r == 3'd0) && payload_r[7]) begin
               acc_err_s = 1'b1;
            end else if ((pkt_cnt_r == 3'd4) && !payload_r[7]) begin
               acc_res_s = 1'b1;
            end else begin
               ferr_s = 1'b1;
            end
         end
      end else begin
         pkt_cnt_nxt_s = pkt_cnt_r;
      end
   end

   // bit FSM, payload shifter and frame assembly registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         type_r    <= 1'b0;
         payload_r <= 8'd0;
         pkt_cnt_r <= 3'd0;
         data_r    <= 32'd0;
      end else begin
         state_r   <= state_nxt_s;
         pkt_cnt_r <= pkt_cnt_nxt_s;
         if (state_r == TYPE) begin
            type_r    <= sin;
            bit_cnt_r <= 3'd0;
         end
         if (state_r == DATA) begin
            payload_r <= {payload_r[6:0], sin};
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end
         if (shift_data_s) data_r <= {data_r[23:0], payload_r};
      end
   end

   // registered outputs; only accepted frames touch the held fields
   always_ff @(posedge clk) begin
      if (rst) begin
         C         <= 32'd0;
         flags     <= 4'd0;
         crc       <= 3'd0;
         err_flags <= 6'd0;
         is_err    <= 1'b0;
         crc_ok    <= 1'b0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= acc_res_s | acc_err_s;
         frame_err <= ferr_s;
         if (acc_res_s) begin
            C      <= data_r;
            flags  <= payload_r[6:3];
            crc    <= payload_r[2:0];
            is_err <= 1'b0;
            crc_ok <= (CHECK_CRC != 0) ?
                      (crc3_f({data_r, 1'b0, payload_r[6:3]}) == payload_r[2:0]) : 1'b1;
         end
         if (acc_err_s) begin
            err_flags <= payload_r[6:1];
            is_err    <= 1'b1;
            crc_ok    <= (CHECK_PARITY != 0) ? parity_ok_f(payload_r) : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mtm_alu_result_rx.sv
module tb_mtm_alu_result_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sin = 1'b1;
   logic [31:0] C;
   logic [3:0]  flags;
   logic [2:0]  crc;
   logic [5:0]  err_flags;
   logic        is_err, crc_ok, valid, frame_err;

   mtm_alu_result_rx #(.CHECK_CRC(1), .CHECK_PARITY(1)) dut (
      .clk(clk), .rst(rst), .sin(sin), .C(C), .flags(flags), .crc(crc),
      .err_flags(err_flags), .is_err(is_err), .crc_ok(crc_ok),
      .valid(valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] kind;   // 2'b10 valid, 2'b01 frame_err
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // reference state: what the outputs should currently hold
   logic [31:0] m_c;
   logic [3:0]  m_flags;
   logic [2:0]  m_crc;
   logic [5:0]  m_err;
   logic        m_is_err, m_crc_ok;
   logic [7:0]  m_frame[$];

   // remainder of (d * x^3) divided by x^3+x+1
   function automatic logic [2:0] crc_ref(input logic [36:0] d);
      logic [39:0] m;
      m = {d, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
      return m[2:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] k);
      exp_t e;
      e.kind = k;
      e.due  = cyc;
      exp_q.push_back(e);
   endtask

   // applies the frame rules to one completed packet
   task automatic model_packet(input logic t, input logic [7:0] p, input logic stop);
      if (!stop) begin
         push_exp(2'b01);
         m_frame.delete();
      end else if (!t) begin
         if (m_frame.size() == 4) begin
            push_exp(2'b01);
            m_frame.delete();
         end else begin
            m_frame.push_back(p);
         end
      end else begin
         if (m_frame.size() == 0 && p[7]) begin
            m_err    = p[6:1];
            m_is_err = 1'b1;
            m_crc_ok = ((^p) == 1'b0);
            push_exp(2'b10);
         end else if (m_frame.size() == 4 && !p[7]) begin
            m_c      = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
            m_flags  = p[6:3];
            m_crc    = p[2:0];
            m_is_err = 1'b0;
            m_crc_ok = (crc_ref({m_c, 1'b0, m_flags}) == m_crc);
            push_exp(2'b10);
         end else begin
            push_exp(2'b01);
         end
         m_frame.delete();
      end
   endtask

   task automatic model_clear();
      m_c = 32'd0; m_flags = 4'd0; m_crc = 3'd0; m_err = 6'd0;
      m_is_err = 1'b0; m_crc_ok = 1'b0;
      m_frame.delete();
      exp_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      tick();
   endtask

   task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
      send_bit(stop);
      model_packet(t, p, stop);
      sin = 1'b1;
   endtask

   task automatic gap();
      int n;
      n = $urandom_range(0, 2);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_result(input logic [31:0] c, input logic [3:0] fl, input logic [2:0] flip);
      logic [2:0] cr;
      for (int i = 3; i >= 0; i--) begin
         send_pkt(1'b0, c[8*i +: 8], 1'b1);
         gap();
      end
      cr = crc_ref({c, 1'b0, fl}) ^ flip;
      send_pkt(1'b1, {1'b0, fl, cr}, 1'b1);
   endtask

   task automatic send_error(input logic [5:0] e, input logic bad);
      logic par;
      par = 1'b1 ^ (^e) ^ bad;
      send_pkt(1'b1, {1'b1, e, par}, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sin = 1'b1;
      tick();
      model_clear();
      tick();
      rst = 1'b0;
   endtask

   // monitor: held outputs every cycle, pulses against the scoreboard
   always @(negedge clk) begin
      chk("C", {32'd0, C}, {32'd0, m_c});
      chk("flags", {60'd0, flags}, {60'd0, m_flags});
      chk("crc", {61'd0, crc}, {61'd0, m_crc});
      chk("err_flags", {58'd0, err_flags}, {58'd0, m_err});
      chk("is_err", {63'd0, is_err}, {63'd0, m_is_err});
      chk("crc_ok", {63'd0, crc_ok}, {63'd0, m_crc_ok});
      chk("pulse_excl", {63'd0, valid & frame_err}, 64'd0);
      if (valid || frame_err) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse at cycle %0d: valid=%0b frame_err=%0b, none expected",
                     cyc, valid, frame_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_kind", {62'd0, valid, frame_err}, {62'd0, e.kind});
            chk("pulse_latency", 64'(cyc), 64'(e.due));
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         tests++;
         fails++;
         $display("FAIL missing_pulse at cycle %0d: got none expected kind %0b due %0d",
                  cyc, exp_q[0].kind, exp_q[0].due);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      model_clear();
      repeat (3) tick();
      rst = 1'b0;

      // directed: reset-release start bit, good frame, bad CRC, error packet
      send_result(32'h0000_0005, 4'b0000, 3'b000);
      gap();
      send_result(32'h0000_0005, 4'b0000, 3'b001);
      send_error(6'b001001, 1'b0);
      send_error(6'b110110, 1'b1);
      // bad stop on the second data packet, then a good frame
      send_pkt(1'b0, 8'hAA, 1'b1);
      send_pkt(1'b0, 8'h55, 1'b0);
      send_result(32'hDEAD_BEEF, 4'b1010, 3'b000);
      // ctl after 2 data packets, then 5 data packets
      send_pkt(1'b0, 8'h11, 1'b1);
      send_pkt(1'b0, 8'h22, 1'b1);
      send_pkt(1'b1, 8'h13, 1'b1);
      for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'(i), 1'b1);
      // ctl with error bit after 4 data packets, ctl without it on empty frame
      for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hF0, 1'b1);
      send_pkt(1'b1, 8'h81, 1'b1);
      send_pkt(1'b1, 8'h12, 1'b1);
      // reset mid-frame after 3 data packets, then a good frame
      for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h77, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      do_reset();
      send_result(32'h1234_5678, 4'b0110, 3'b000);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = $urandom_range(0, 5);
         case (sel)
            0: send_result($urandom, 4'($urandom), 3'b000);
            1: send_result($urandom, 4'($urandom), 3'($urandom_range(1, 7)));
            2: send_error(6'($urandom), 1'b0);
            3: send_error(6'($urandom), 1'b1);
            4: send_pkt(1'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0));
            default: begin
               int bad;
               logic [31:0] c;
               bad = $urandom_range(0, 3);
               c = $urandom;
               for (int i = 3; i >= 0; i--)
                  send_pkt(1'b0, c[8*i +: 8], (i != bad));
               send_result($urandom, 4'($urandom), 3'b000);
            end
         endcase
         gap();
      end

      // drain with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      tick();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
